// File: rtl/crt_pkg.sv
// Shared types and sizing helpers for the CRT reconstruction engine.
package crt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REDUCE,
    ST_INV,
    ST_UPDATE,
    ST_DONE
  } crt_state_e;

  typedef enum logic {
    INV_IDLE,
    INV_RUN
  } inv_state_e;

  localparam int unsigned CRT_NUM_MOD = 4;
  localparam int unsigned CRT_MOD_W   = 4;

  function automatic int unsigned crt_out_w(input int unsigned num_mod, input int unsigned mod_w);
    return num_mod * mod_w;
  endfunction

  // Worst case cycles from accept to out_valid.
  function automatic int unsigned crt_max_latency(input int unsigned num_mod, input int unsigned mod_w);
    return 2 + (num_mod - 1) * (2 * mod_w + 6);
  endfunction

  localparam int unsigned CRT_MAX_LAT = crt_max_latency(CRT_NUM_MOD, CRT_MOD_W);

endpackage

// File: rtl/crt_reconstruct_seq_if.sv
// Job/result handshake bundle between a producer/consumer and the CRT engine.
interface crt_reconstruct_seq_if
  import crt_pkg::*;
#(
  parameter int unsigned NUM_MOD = 4,
  parameter int unsigned MOD_W   = 4
);
  localparam int unsigned OUT_W = crt_out_w(NUM_MOD, MOD_W);

  logic [NUM_MOD*MOD_W-1:0] m;
  logic [NUM_MOD*MOD_W-1:0] x;
  logic                     in_valid;
  logic                     in_ready;
  logic [OUT_W-1:0]         result;
  logic [OUT_W-1:0]         modulus;
  logic                     error;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output m, x, in_valid, out_ready,
    input  in_ready, result, modulus, error, out_valid
  );

  modport slave (
    input  m, x, in_valid, out_ready,
    output in_ready, result, modulus, error, out_valid
  );

endinterface

// File: rtl/mod_inverse_seq.sv
// Iterative extended Euclid: inverse of a modulo n, one quotient step per cycle.
module mod_inverse_seq
  import crt_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] n,
  output logic         done,
  output logic         valid,
  output logic [W-1:0] inv
);

  // Bezout coefficients stay within +/-n; two spare bits hold the sign safely.
  localparam int unsigned TW = W + 2;

  inv_state_e           state_q, state_d;
  logic [W-1:0]         n_q, n_d;
  logic [W-1:0]         r0_q, r0_d;
  logic [W-1:0]         r1_q, r1_d;
  logic signed [TW-1:0] t0_q, t0_d;
  logic signed [TW-1:0] t1_q, t1_d;
  logic                 done_d, valid_d;
  logic [W-1:0]         inv_d;
  logic [W-1:0]         q;
  logic signed [TW-1:0] t_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INV_IDLE;
      n_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      done    <= 1'b0;
      valid   <= 1'b0;
      inv     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      done    <= done_d;
      valid   <= valid_d;
      inv     <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    done_d  = 1'b0;
    valid_d = valid;
    inv_d   = inv;
    q       = '0;
    t_fix   = '0;

    unique case (state_q)
      INV_IDLE: begin
        if (start) begin
          if (n == '0) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            inv_d   = '0;
          end else begin
            n_d     = n;
            r0_d    = n;
            r1_d    = a % n;
            t0_d    = '0;
            t1_d    = TW'(1);
            state_d = INV_RUN;
          end
        end
      end
      INV_RUN: begin
        if (r1_q == '0) begin
          // Remainder exhausted: r0 is the gcd, t0 the coefficient of a.
          t_fix   = t0_q[TW-1] ? (t0_q + $signed(TW'(n_q))) : t0_q;
          done_d  = 1'b1;
          valid_d = (r0_q == W'(1));
          inv_d   = (r0_q == W'(1)) ? W'(t_fix) : '0;
          state_d = INV_IDLE;
        end else begin
          q    = r0_q / r1_q;
          r0_d = r1_q;
          r1_d = r0_q % r1_q;
          t0_d = t1_q;
          t1_d = t0_q - TW'($signed({2'b00, q}) * t1_q);
        end
      end
      default: state_d = INV_IDLE;
    endcase
  end

endmodule

// File: rtl/crt_reconstruct_seq.sv
// Sequential Garner mixed-radix CRT reconstruction: one channel per outer pass.
module crt_reconstruct_seq
  import crt_pkg::*;
#(
  parameter int unsigned NUM_MOD = 4,
  parameter int unsigned MOD_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  crt_reconstruct_seq_if.slave  bus
);

  localparam int unsigned OUT_W = crt_out_w(NUM_MOD, MOD_W);
  localparam int unsigned IN_W  = NUM_MOD * MOD_W;
  localparam int unsigned IW    = $clog2(NUM_MOD);
  localparam int unsigned DW    = MOD_W + 1;
  localparam int unsigned PW    = 2 * MOD_W;

  crt_state_e        state_q, state_d;
  logic [IN_W-1:0]   m_q, m_d;
  logic [IN_W-1:0]   x_q, x_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0]  acc_x_q, acc_x_d;
  logic [OUT_W-1:0]  acc_m_q, acc_m_d;
  logic [MOD_W-1:0]  a_q, a_d;
  logic [MOD_W-1:0]  xi_q, xi_d;
  logic              start_q, start_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic [OUT_W-1:0]  modulus_q, modulus_d;
  logic              error_q, error_d;
  logic              fail;

  logic [MOD_W-1:0]  m_i, x_i, ax, t;
  logic [DW-1:0]     diff;
  logic [PW-1:0]     prod;
  logic              inv_done, inv_valid;
  logic [MOD_W-1:0]  inv;

  mod_inverse_seq #(.W(MOD_W)) u_inv (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .a     (a_q),
    .n     (m_i),
    .done  (inv_done),
    .valid (inv_valid),
    .inv   (inv)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.modulus   = modulus_q;
  assign bus.error     = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      x_q         <= '0;
      idx_q       <= '0;
      acc_x_q     <= '0;
      acc_m_q     <= '0;
      a_q         <= '0;
      xi_q        <= '0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      modulus_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      x_q         <= x_d;
      idx_q       <= idx_d;
      acc_x_q     <= acc_x_d;
      acc_m_q     <= acc_m_d;
      a_q         <= a_d;
      xi_q        <= xi_d;
      start_q     <= start_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      modulus_q   <= modulus_d;
      error_q     <= error_d;
    end
  end

  // Current channel and Garner digit t = (xi - acc_x) * inv mod m_i.
  always_comb begin
    m_i  = m_q[32'(idx_q) * MOD_W +: MOD_W];
    x_i  = x_q[32'(idx_q) * MOD_W +: MOD_W];
    ax   = '0;
    diff = '0;
    prod = '0;
    t    = '0;
    if (m_i != '0) begin
      ax   = MOD_W'(acc_x_q % OUT_W'(m_i));
      diff = ({1'b0, xi_q} + {1'b0, m_i} - {1'b0, ax}) % {1'b0, m_i};
      prod = PW'(diff) * PW'(inv);
      t    = MOD_W'(prod % PW'(m_i));
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    x_d         = x_q;
    idx_d       = idx_q;
    acc_x_d     = acc_x_q;
    acc_m_d     = acc_m_q;
    a_d         = a_q;
    xi_d        = xi_q;
    start_d     = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    modulus_d   = modulus_q;
    error_d     = error_q;
    fail        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          m_d        = bus.m;
          x_d        = bus.x;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (m_q[MOD_W-1:0] == '0) begin
          fail = 1'b1;
        end else begin
          acc_x_d = OUT_W'(x_q[MOD_W-1:0] % m_q[MOD_W-1:0]);
          acc_m_d = OUT_W'(m_q[MOD_W-1:0]);
          idx_d   = IW'(1);
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (m_i == '0) begin
          fail = 1'b1;
        end else begin
          a_d     = MOD_W'(acc_m_q % OUT_W'(m_i));
          xi_d    = x_i % m_i;
          start_d = 1'b1;
          state_d = ST_INV;
        end
      end
      ST_INV: begin
        if (inv_done) begin
          if (!inv_valid) fail = 1'b1;
          else            state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        acc_x_d = acc_x_q + acc_m_q * OUT_W'(t);
        acc_m_d = acc_m_q * OUT_W'(m_i);
        if (idx_q == IW'(NUM_MOD - 1)) begin
          out_valid_d = 1'b1;
          error_d     = 1'b0;
          result_d    = acc_x_d;
          modulus_d   = acc_m_d;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_REDUCE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero modulus or non-coprime channel: report error with zeroed payload.
    if (fail) begin
      out_valid_d = 1'b1;
      error_d     = 1'b1;
      result_d    = '0;
      modulus_d   = '0;
      state_d     = ST_DONE;
    end
  end

endmodule
